fifo_out_sink: RTL and testbench
================================

Name: fifo_out_sink

Overview:
- Receiving end of the ap_fifo output stream that HLS kernels drive through `<port>_din`, `<port>_write` and `<port>_full_n`.
- Replaces the tie-off `full_n = 1` with real backpressure from a small buffer.
- Drains the buffer at a programmable rate, emits one XOR-folded nibble per word on the board output pins, and reports a per-run signature and word count when the kernel signals `ap_done`.
- Sits between the kernel instance and the top-level `data_out`/`data_valid` pins.

Parameters:
- DATA_WIDTH, 32, width of the kernel stream word; multiple of 8.
- FIFO_DEPTH, 16, number of buffer entries; power of 2.
- ADDR_WIDTH, 4, clog2(FIFO_DEPTH).
- DRAIN_INV, 1, minimum cycles between pops; 1 means one pop per cycle; legal range 1..255.

Ports:
- ap_clk  in  1  sole clock.
- ap_rst  in  1  asynchronous, active-low reset.
- y_din  in  DATA_WIDTH  stream data from the kernel.
- y_write  in  1  kernel write strobe.
- y_full_n  out  1  buffer not-full, returned to the kernel.
- ap_done  in  1  kernel completion pulse.
- data_out  out  4  folded nibble.
- data_valid  out  1  data_out qualifier.
- sig_out  out  32  run signature.
- word_cnt  out  16  words popped in the run.
- sig_valid  out  1  one-cycle pulse qualifying sig_out and word_cnt.
- overflow  out  1  sticky protocol-violation flag.

Behaviour:
- Reset (ap_rst=0, asynchronous):
  - Pointers, occupancy count, drain timer, signature accumulator and word counter are cleared.
  - data_out=0, data_valid=0, sig_out=0, word_cnt=0, sig_valid=0, overflow=0; state=RUN.
  - y_full_n=1 during and after reset.
  - Reset mid-run discards buffered data; no sig_valid pulse is produced.
- y_full_n is combinational: high when count != FIFO_DEPTH.
- Push: occurs when y_write && y_full_n; y_din is written at the write pointer, and the pointer wraps mod FIFO_DEPTH.
- y_write while full: the word is dropped and overflow is set to 1; overflow stays set until reset.
- Pop: occurs when count != 0 && drain timer == 0.
  - The read pointer advances with wrap.
  - The drain timer reloads to DRAIN_INV-1 and then decrements to 0.
- Simultaneous push and pop: count is unchanged. A pop at count==FIFO_DEPTH raises y_full_n on the next cycle, not the same cycle.
- Fold: byte-XOR of the popped word, then high nibble XOR low nibble.
- Output timing: data_out and data_valid are registered 1 cycle after the pop.
  - data_valid=1 for exactly one cycle per word.
  - data_out=0 whenever data_valid=0.
- Signature, updated on each pop:
  - sig_acc <= {sig_acc[30:0], sig_acc[31]} ^ word. The word is zero-extended or truncated to 32 bits.
  - cnt_acc increments and saturates at 0xFFFF.
- State machine:
  - RUN: an ap_done pulse moves to FLUSH. Further ap_done pulses are ignored until REPORT completes.
  - FLUSH: pushes are still accepted. Transition to REPORT when count==0 and no pop is in flight.
  - REPORT, one cycle:
    - sig_out <= sig_acc, word_cnt <= cnt_acc, sig_valid=1 on the following cycle.
    - sig_acc and cnt_acc are cleared; the state returns to RUN.
    - sig_out and word_cnt hold their values until the next report.
- ap_done with an empty buffer: sig_valid is asserted 2 cycles after ap_done.
- ap_done in the same cycle as the last push: that word is included in the report.
- Zero-word run: sig_valid pulses with sig_out=0 and word_cnt=0.

Test Plan:
- Single word: push 0x12345678 on an idle buffer → data_valid at pop+1 with data_out=0x8.
- Two-word run: push 0x12345678 then 0x00000001, then pulse ap_done → fold nibbles 0x8 and 0x1. sig_valid pulses once with sig_out=0x2468ACF1 and word_cnt=2, after which the accumulators are cleared.
- Backpressure, DRAIN_INV=4: the kernel honors y_full_n while writing 40 words → y_full_n drops when count reaches 16, no word is lost, overflow stays 0, word_cnt=40, and data_valid spacing is ≥4 cycles.
- Protocol violation: with DRAIN_INV=255, hold y_write=1 for 20 cycles with word values 0..19 → words 16..19 are dropped and overflow=1 until reset.
- Edge values: push 0xFFFFFFFF, then 0x000000A5 → data_out 0x0, then 0xF. ap_done on an empty buffer gives sig_valid 2 cycles later with word_cnt=0.
- Reset mid-run: assert ap_rst with 5 words buffered → all outputs are 0 immediately, y_full_n=1, and no sig_valid pulse follows.

Source files
------------

// File: rtl/fifo_out_sink.sv
// rtl/fifo_out_sink.sv - buffered ap_fifo sink with paced drain, nibble fold and per-run signature
// Gives HLS kernels real backpressure and reports a signature/word count on ap_done.
module fifo_out_sink #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int DRAIN_INV  = 1
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic [DATA_WIDTH-1:0] y_din,
  input  logic                  y_write,
  output logic                  y_full_n,
  input  logic                  ap_done,
  output logic [3:0]            data_out,
  output logic                  data_valid,
  output logic [31:0]           sig_out,
  output logic [15:0]           word_cnt,
  output logic                  sig_valid,
  output logic                  overflow
);

  typedef enum logic [1:0] {ST_RUN, ST_FLUSH, ST_REPORT} state_t;

  localparam logic [ADDR_WIDTH:0] L_FULL   = (ADDR_WIDTH+1)'(FIFO_DEPTH);
  localparam logic [7:0]          L_RELOAD = 8'(DRAIN_INV - 1);

  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic [7:0]            r_timer;
  logic [31:0]           r_sig_acc;
  logic [15:0]           r_cnt_acc;
  state_t                r_state;
  logic [3:0]            r_data_out;
  logic                  r_data_valid;
  logic [31:0]           r_sig_out;
  logic [15:0]           r_word_cnt;
  logic                  r_sig_valid;
  logic                  r_overflow;

  logic                  w_push;
  logic                  w_pop;
  logic                  w_report_go;
  logic [DATA_WIDTH-1:0] w_rd_word;
  logic [31:0]           w_word32;
  logic [7:0]            w_byte_x;
  logic [3:0]            w_fold;

  assign y_full_n    = (r_count != L_FULL);
  assign w_push      = y_write && y_full_n;
  assign w_pop       = (r_count != '0) && (r_timer == 8'd0);
  // An empty buffer means nothing is left to pop into the accumulators.
  assign w_report_go = (r_state == ST_FLUSH) && (r_count == '0);
  assign w_rd_word   = r_mem[r_rd_ptr];
  assign w_word32    = 32'(w_rd_word);

  always_comb begin
    w_byte_x = '0;
    for (int i = 0; i < DATA_WIDTH / 8; i++) begin
      w_byte_x = w_byte_x ^ w_rd_word[i*8 +: 8];
    end
  end
  assign w_fold = w_byte_x[7:4] ^ w_byte_x[3:0];

  always_ff @(posedge ap_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= y_din;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst) begin
    if (!ap_rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_timer      <= 8'd0;
      r_sig_acc    <= 32'd0;
      r_cnt_acc    <= 16'd0;
      r_state      <= ST_RUN;
      r_data_out   <= 4'd0;
      r_data_valid <= 1'b0;
      r_sig_out    <= 32'd0;
      r_word_cnt   <= 16'd0;
      r_sig_valid  <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase

      if (w_pop) begin
        r_timer <= L_RELOAD;
      end else if (r_timer != 8'd0) begin
        r_timer <= r_timer - 8'd1;
      end

      r_data_valid <= w_pop;
      r_data_out   <= w_pop ? w_fold : 4'd0;

      if (y_write && !y_full_n) begin
        r_overflow <= 1'b1;
      end

      r_sig_valid <= 1'b0;
      if (w_report_go) begin
        r_sig_out   <= r_sig_acc;
        r_word_cnt  <= r_cnt_acc;
        r_sig_valid <= 1'b1;
        r_sig_acc   <= 32'd0;
        r_cnt_acc   <= 16'd0;
      end else if (w_pop) begin
        r_sig_acc <= {r_sig_acc[30:0], r_sig_acc[31]} ^ w_word32;
        if (r_cnt_acc != 16'hFFFF) begin
          r_cnt_acc <= r_cnt_acc + 16'd1;
        end
      end

      // Further ap_done pulses are ignored until the report has gone out.
      case (r_state)
        ST_RUN:    if (ap_done) r_state <= ST_FLUSH;
        ST_FLUSH:  if (w_report_go) r_state <= ST_REPORT;
        ST_REPORT: r_state <= ST_RUN;
        default:   r_state <= ST_RUN;
      endcase
    end
  end

  assign data_out   = r_data_out;
  assign data_valid = r_data_valid;
  assign sig_out    = r_sig_out;
  assign word_cnt   = r_word_cnt;
  assign sig_valid  = r_sig_valid;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_fifo_out_sink.sv
// tb/tb_fifo_out_sink.sv - scoreboard bench for fifo_out_sink
// Three instances differ only in DRAIN_INV; sel picks the one being checked.
module tb_fifo_out_sink;

  localparam int DI [3] = '{1, 4, 255};

  logic        ap_clk  = 1'b0;
  logic        ap_rst  = 1'b0;
  logic [31:0] y_din   = 32'd0;
  logic        y_write = 1'b0;
  logic        ap_done = 1'b0;

  logic [2:0]        full_n_v;
  logic [2:0][3:0]   dout_v;
  logic [2:0]        dv_v;
  logic [2:0][31:0]  sig_v;
  logic [2:0][15:0]  wc_v;
  logic [2:0]        sv_v;
  logic [2:0]        ovf_v;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    fifo_out_sink #(
      .DATA_WIDTH(32), .FIFO_DEPTH(16), .ADDR_WIDTH(4), .DRAIN_INV(DI[g])
    ) u_dut (
      .ap_clk(ap_clk), .ap_rst(ap_rst), .y_din(y_din), .y_write(y_write),
      .y_full_n(full_n_v[g]), .ap_done(ap_done), .data_out(dout_v[g]),
      .data_valid(dv_v[g]), .sig_out(sig_v[g]), .word_cnt(wc_v[g]),
      .sig_valid(sv_v[g]), .overflow(ovf_v[g])
    );
  end

  always #5 ap_clk = ~ap_clk;

  logic [1:0]  sel = 2'd0;
  wire         s_full_n = full_n_v[sel];
  wire  [3:0]  s_dout   = dout_v[sel];
  wire         s_dv     = dv_v[sel];
  wire  [31:0] s_sig    = sig_v[sel];
  wire  [15:0] s_wc     = wc_v[sel];
  wire         s_sv     = sv_v[sel];
  wire         s_ovf    = ovf_v[sel];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  always @(posedge ap_clk) cyc <= cyc + 1;

  logic [3:0]  q_nib [$];
  logic [47:0] q_rep [$];
  logic [31:0] sig_m = 32'd0;
  logic [15:0] cnt_m = 16'd0;

  int last_dv = 0, last_sv = 0, n_dv = 0, n_sv = 0, min_gap = 1000000;
  bit have_dv = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] fold_ref(input logic [31:0] w);
    logic [3:0] x = 4'd0;
    for (int i = 0; i < 8; i++) x = x ^ w[4*i +: 4];
    return x;
  endfunction

  task automatic accept(input logic [31:0] w);
    q_nib.push_back(fold_ref(w));
    sig_m = {sig_m[30:0], sig_m[31]} ^ w;
    if (cnt_m != 16'hFFFF) cnt_m = cnt_m + 16'd1;
  endtask

  task automatic report_expect();
    q_rep.push_back({sig_m, cnt_m});
    sig_m = 32'd0;
    cnt_m = 16'd0;
  endtask

  task automatic cycle_drive(input logic wr, input logic [31:0] din, input logic done);
    @(posedge ap_clk);
    #1;
    y_write = wr;
    y_din   = din;
    ap_done = done;
  endtask

  task automatic wait_drain(input int maxc);
    int i = 0;
    while (i < maxc && (q_nib.size() != 0 || q_rep.size() != 0)) begin
      @(posedge ap_clk);
      i++;
    end
    chk("drain_pending", q_nib.size() + q_rep.size(), 0);
    repeat (3) @(posedge ap_clk);
  endtask

  task automatic do_reset();
    @(posedge ap_clk);
    #1;
    ap_rst = 1'b0; y_write = 1'b0; ap_done = 1'b0;
    q_nib.delete(); q_rep.delete();
    sig_m = 32'd0; cnt_m = 16'd0;
    repeat (2) @(posedge ap_clk);
    #1;
    chk("full_n_in_reset", s_full_n, 1);
    ap_rst = 1'b1;
    have_dv = 1'b0;
  endtask

  always @(negedge ap_clk) begin
    if (s_dv) begin
      if (q_nib.size() == 0) chk("dv_unexpected", 1, 0);
      else chk("data_out", s_dout, q_nib.pop_front());
      if (have_dv && (cyc - last_dv) < min_gap) min_gap = cyc - last_dv;
      last_dv = cyc; have_dv = 1'b1; n_dv++;
    end else begin
      chk("data_out_idle", s_dout, 0);
    end
    if (s_sv) begin
      last_sv = cyc; n_sv++;
      if (q_rep.size() == 0) chk("sig_valid_unexpected", 1, 0);
      else begin
        logic [47:0] r;
        r = q_rep.pop_front();
        chk("sig_out", s_sig, r[47:16]);
        chk("word_cnt", s_wc, r[15:0]);
      end
    end
  end

  initial begin
    int push_cyc, done_cyc, n_sv0, n_dv0, guard, k;
    bit saw_full;

    // reset state
    sel = 2'd0;
    do_reset();
    #1;
    chk("rst_data_out", s_dout, 0);
    chk("rst_data_valid", s_dv, 0);
    chk("rst_sig_out", s_sig, 0);
    chk("rst_word_cnt", s_wc, 0);
    chk("rst_sig_valid", s_sv, 0);
    chk("rst_overflow", s_ovf, 0);
    chk("rst_full_n", s_full_n, 1);

    // single word and pop latency
    cycle_drive(1'b1, 32'h12345678, 1'b0);
    accept(32'h12345678);
    push_cyc = cyc;
    cycle_drive(1'b0, 32'd0, 1'b0);
    wait_drain(20);
    chk("pop_latency", last_dv - push_cyc, 2);

    // second word, then ap_done closes the two-word run
    n_sv0 = n_sv;
    cycle_drive(1'b1, 32'h00000001, 1'b0);
    accept(32'h00000001);
    cycle_drive(1'b0, 32'd0, 1'b1);
    chk("two_word_sig_model", sig_m, 32'h2468ACF1);
    report_expect();
    cycle_drive(1'b0, 32'd0, 1'b0);
    wait_drain(40);
    chk("two_word_sig_pulses", n_sv - n_sv0, 1);

    // edge values; ap_done shares a cycle with the last push
    cycle_drive(1'b1, 32'hFFFFFFFF, 1'b0);
    accept(32'hFFFFFFFF);
    cycle_drive(1'b1, 32'h000000A5, 1'b1);
    accept(32'h000000A5);
    report_expect();
    cycle_drive(1'b0, 32'd0, 1'b0);
    wait_drain(40);

    // ap_done on an empty buffer: zero-word report two cycles later
    cycle_drive(1'b0, 32'd0, 1'b1);
    done_cyc = cyc;
    report_expect();
    cycle_drive(1'b0, 32'd0, 1'b0);
    wait_drain(20);
    chk("empty_done_latency", last_sv - done_cyc, 2);

    // backpressure with DRAIN_INV=4, kernel honours y_full_n
    sel = 2'd1;
    do_reset();
    min_gap = 1000000; n_dv0 = n_dv; saw_full = 1'b0; k = 0; guard = 0;
    while (k < 40 && guard < 2000) begin
      @(posedge ap_clk);
      #1;
      guard++;
      if (!s_full_n) begin
        saw_full = 1'b1;
        y_write = 1'b0;
      end else begin
        y_write = 1'b1;
        y_din = $urandom;
        accept(y_din);
        k++;
      end
    end
    chk("bp_all_written", k, 40);
    cycle_drive(1'b0, 32'd0, 1'b1);
    report_expect();
    cycle_drive(1'b0, 32'd0, 1'b0);
    wait_drain(600);
    chk("bp_full_seen", saw_full, 1);
    chk("bp_overflow", s_ovf, 0);
    chk("bp_dv_count", n_dv - n_dv0, 40);
    chk("bp_dv_spacing", min_gap, 4);

    // protocol violation with DRAIN_INV=255; warm-up pop arms the drain timer
    sel = 2'd2;
    do_reset();
    cycle_drive(1'b1, 32'hCAFE0000, 1'b0);
    accept(32'hCAFE0000);
    cycle_drive(1'b0, 32'd0, 1'b0);
    repeat (3) @(posedge ap_clk);
    for (int i = 0; i < 20; i++) begin
      cycle_drive(1'b1, 32'(i), 1'b0);
      if (i < 16) accept(32'(i));
    end
    cycle_drive(1'b0, 32'd0, 1'b0);
    #1;
    chk("viol_overflow", s_ovf, 1);
    chk("viol_full_n", s_full_n, 0);
    wait_drain(4600);
    chk("viol_overflow_sticky", s_ovf, 1);

    // reset mid-run with words buffered
    do_reset();
    chk("rst_clears_overflow", s_ovf, 0);
    for (int i = 0; i < 5; i++) begin
      cycle_drive(1'b1, 32'h100 + 32'(i), 1'b0);
      accept(32'h100 + 32'(i));
    end
    cycle_drive(1'b0, 32'd0, 1'b1);
    cycle_drive(1'b0, 32'd0, 1'b0);
    #2;
    ap_rst = 1'b0;
    #1;
    q_nib.delete(); q_rep.delete();
    sig_m = 32'd0; cnt_m = 16'd0;
    n_sv0 = n_sv;
    chk("midrst_data_out", s_dout, 0);
    chk("midrst_data_valid", s_dv, 0);
    chk("midrst_sig_valid", s_sv, 0);
    chk("midrst_word_cnt", s_wc, 0);
    chk("midrst_sig_out", s_sig, 0);
    chk("midrst_full_n", s_full_n, 1);
    repeat (2) @(posedge ap_clk);
    #1;
    ap_rst = 1'b1;
    repeat (20) @(posedge ap_clk);
    chk("midrst_no_sig", n_sv - n_sv0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
